seg_display_driver: RTL

Output-side counterpart to the input synchronizers. It takes the 16-bit signed product from the multiplier datapath and converts it sequentially to sign plus five BCD digits. It then drives the Basys 3 four-digit, active-low, multiplexed seven-segment display. A page input selects which half of the result is visible.

---
 rtl/seg_pkg.sv | 25 ++
 rtl/bin2bcd_seq.sv | 70 +++++++
 rtl/seg_display_driver.sv | 112 +++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared segment encodings, converter FSM states and the digit lookup
// for the seven-segment output path.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  // Active-low {g,f,e,d,c,b,a}; entry [0] is the digit 0.
  localparam logic [9:0][6:0] SEG_DIGIT = {
    7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
    7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } bcd_state_t;

  function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
    if (d > 4'd9) return SEG_BLANK;
    return SEG_DIGIT[d];
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 16-bit unsigned in, five BCD nibbles out
// after 16 shift cycles plus one commit cycle.
module bin2bcd_seq
  import seg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] bin,
  output logic        busy,
  output logic        done,
  output logic [19:0] bcd
);

  bcd_state_t  state;
  logic [15:0] mag_reg;
  logic [19:0] acc_reg;
  logic [3:0]  iter_reg;
  logic [19:0] acc_adj;

  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_adj
      assign acc_adj[gi*4 +: 4] = (acc_reg[gi*4 +: 4] >= 4'd5) ?
                                  acc_reg[gi*4 +: 4] + 4'd3 : acc_reg[gi*4 +: 4];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      mag_reg  <= '0;
      acc_reg  <= '0;
      iter_reg <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mag_reg  <= bin;
            acc_reg  <= '0;
            iter_reg <= '0;
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          {acc_reg, mag_reg} <= {acc_adj, mag_reg} << 1;
          iter_reg <= iter_reg + 4'd1;
          if (iter_reg == 4'd15) begin
            state <= COMMIT;
            done  <= 1'b1;
          end
        end
        COMMIT: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bcd = acc_reg;

endmodule

// File: rtl/seg_display_driver.sv
// Signed 16-bit result to sign + five BCD digits, scanned onto the
// four-digit multiplexed active-low seven-segment display.
module seg_display_driver
  import seg_pkg::*;
#(
  parameter int DIGIT_PERIOD = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic        load,
  input  logic        page,
  output logic        busy,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam int CW = $clog2(DIGIT_PERIOD);
  localparam logic [CW-1:0] LAST = CW'(DIGIT_PERIOD - 1);

  logic        start;
  logic [15:0] mag;
  logic        neg_reg;
  logic        done;
  logic [19:0] bcd;
  logic [19:0] disp_reg;
  logic        disp_neg_reg;
  logic [CW-1:0] refresh_reg;
  logic [1:0]  idx_reg;
  logic [3:0]  dig [5];
  logic        show1, show2, show3;
  logic [3:0]  an_next;
  logic [6:0]  seg_next;

  assign start = load && !busy;
  assign mag   = value[15] ? -value : value;

  bin2bcd_seq u_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (mag),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  // Display register only changes on commit, so the old result stays up meanwhile.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      neg_reg      <= 1'b0;
      disp_reg     <= '0;
      disp_neg_reg <= 1'b0;
    end else begin
      if (start) neg_reg <= value[15];
      if (done) begin
        disp_reg     <= bcd;
        disp_neg_reg <= neg_reg && (bcd != 20'd0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      refresh_reg <= '0;
      idx_reg     <= 2'd0;
      an          <= 4'b1111;
      seg         <= SEG_BLANK;
    end else begin
      if (refresh_reg == LAST) begin
        refresh_reg <= '0;
        idx_reg     <= idx_reg + 2'd1;
      end else begin
        refresh_reg <= refresh_reg + 1'b1;
      end
      an  <= an_next;
      seg <= seg_next;
    end
  end

  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_dig
      assign dig[gi] = disp_reg[gi*4 +: 4];
    end
  endgenerate

  assign show3 = (dig[3] != 4'd0);
  assign show2 = show3 || (dig[2] != 4'd0);
  assign show1 = show2 || (dig[1] != 4'd0);

  assign an_next = ~(4'b0001 << idx_reg);

  always_comb begin
    seg_next = SEG_BLANK;
    if (!page) begin
      case (idx_reg)
        2'd0: seg_next = digit_to_seg(dig[0]);
        2'd1: if (show1) seg_next = digit_to_seg(dig[1]);
        2'd2: if (show2) seg_next = digit_to_seg(dig[2]);
        2'd3: if (show3) seg_next = digit_to_seg(dig[3]);
        default: seg_next = SEG_BLANK;
      endcase
    end else begin
      case (idx_reg)
        2'd0: if ((dig[4] != 4'd0) || disp_neg_reg) seg_next = digit_to_seg(dig[4]);
        2'd1: if (disp_neg_reg) seg_next = SEG_MINUS;
        default: seg_next = SEG_BLANK;
      endcase
    end
  end

endmodule
